// File: rtl/mem_stage_hs.sv
// mem_stage_hs: pipeline Memory stage with a req/ack data-memory handshake.
// It stalls upstream while an access is outstanding, builds byte enables and
// lane-replicated store data, and extends load data into the MEM/WB register.
// Optional feature macro: MEM_MISALIGN_CHECK_EN. When it is defined, a
// misaligned halfword/word/double access is trapped into WB with misalign_w=1.
//
// state  | meaning
// IDLE   | no access outstanding; a new access requests in its first cycle
// WAIT   | request issued and not yet acknowledged; M inputs are held upstream
module mem_stage_hs #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_m,
    input  logic                 reg_write_m,
    input  logic                 mem_write_m,
    input  logic                 mem_read_m,
    input  logic [1:0]           result_src_m,
    input  logic [2:0]           funct3_m,
    input  logic [A_WIDTH-1:0]   rd_m,
    input  logic [D_WIDTH-1:0]   alu_result_m,
    input  logic [D_WIDTH-1:0]   write_data_m,
    input  logic [D_WIDTH-1:0]   pc_plus4_m,
    input  logic                 flush_m,
    output logic                 stall_m,
    output logic                 reg_write_m_fwd,
    output logic [A_WIDTH-1:0]   rd_m_fwd,
    output logic [D_WIDTH-1:0]   alu_result_m_fwd,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [D_WIDTH-1:0]   dmem_addr,
    output logic [D_WIDTH-1:0]   dmem_wdata,
    output logic [D_WIDTH/8-1:0] dmem_be,
    input  logic                 dmem_ack,
    input  logic [D_WIDTH-1:0]   dmem_rdata,
    output logic                 valid_w,
    output logic                 reg_write_w,
    output logic [1:0]           result_src_w,
    output logic [A_WIDTH-1:0]   rd_w,
    output logic [D_WIDTH-1:0]   alu_result_w,
    output logic [D_WIDTH-1:0]   read_data_w,
    output logic [D_WIDTH-1:0]   pc_plus4_w,
    output logic                 misalign_w
);

    localparam int NB = D_WIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam logic [NB-1:0] BE_B = NB'(1);
    localparam logic [NB-1:0] BE_H = NB'(3);
    localparam logic [NB-1:0] BE_W = NB'(15);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t state;

    logic [LB-1:0]      lane;
    logic [LB-1:0]      base;
    logic [NB-1:0]      be_calc;
    logic [D_WIDTH-1:0] wdata_calc;
    logic [D_WIDTH-1:0] shifted;
    logic [D_WIDTH-1:0] rdata_fmt;
    logic               is_mem;
    logic               misalign;
    logic               mis_m;
    logic               access;
    logic               req_on;

    assign lane   = alu_result_m[LB-1:0];
    assign is_mem = valid_m & (mem_read_m | mem_write_m);

`ifdef MEM_MISALIGN_CHECK_EN
    // Alignment is judged against the access size encoded in funct3[1:0].
    always_comb begin
        misalign = 1'b0;
        case (funct3_m[1:0])
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = alu_result_m[0];
            2'b10:   misalign = |alu_result_m[1:0];
            default: misalign = |alu_result_m[2:0];
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    assign mis_m = is_mem & misalign;

    // Once waiting, the transaction runs to completion regardless of flush_m.
    assign access = (state == S_WAIT) | (is_mem & ~flush_m & ~misalign);
    assign req_on = rst_n & access;

    assign dmem_req   = req_on;
    assign dmem_we    = req_on & mem_write_m;
    assign dmem_be    = req_on ? be_calc : '0;
    assign stall_m    = req_on & ~dmem_ack;
    assign dmem_addr  = {alu_result_m[D_WIDTH-1:LB], {LB{1'b0}}};
    assign dmem_wdata = wdata_calc;

    assign reg_write_m_fwd  = reg_write_m & valid_m;
    assign rd_m_fwd         = rd_m;
    assign alu_result_m_fwd = alu_result_m;

    // Size-aligned lane base; lane bits below the access size are ignored.
    always_comb begin
        base = '0;
        case (funct3_m[1:0])
            2'b00:   base = lane;
            2'b01:   base = lane & LB'(NB - 2);
            2'b10:   base = lane & LB'(NB - 4);
            default: base = '0;
        endcase
    end

    // Byte enables and replicated store data for the access size.
    always_comb begin
        be_calc    = '0;
        wdata_calc = write_data_m;
        case (funct3_m[1:0])
            2'b00: begin
                be_calc    = BE_B << base;
                wdata_calc = {NB{write_data_m[7:0]}};
            end
            2'b01: begin
                be_calc    = BE_H << base;
                wdata_calc = {(D_WIDTH/16){write_data_m[15:0]}};
            end
            2'b10: begin
                be_calc    = BE_W << base;
                wdata_calc = {(D_WIDTH/32){write_data_m[31:0]}};
            end
            default: begin
                be_calc    = (NB == 8) ? '1 : '0;
                wdata_calc = write_data_m;
            end
        endcase
    end

    assign shifted = dmem_rdata >> {base, 3'b000};

    // Extend the selected lane of the read data according to funct3.
    always_comb begin
        rdata_fmt = '0;
        case (funct3_m)
            3'b000:  rdata_fmt = D_WIDTH'($signed(shifted[7:0]));
            3'b001:  rdata_fmt = D_WIDTH'($signed(shifted[15:0]));
            3'b010:  rdata_fmt = D_WIDTH'($signed(shifted[31:0]));
            3'b011:  rdata_fmt = (NB == 8) ? shifted : '0;
            3'b100:  rdata_fmt = D_WIDTH'(shifted[7:0]);
            3'b101:  rdata_fmt = D_WIDTH'(shifted[15:0]);
            3'b110:  rdata_fmt = (NB == 8) ? D_WIDTH'(shifted[31:0]) : '0;
            default: rdata_fmt = '0;
        endcase
    end

    // Handshake FSM: leave IDLE only when an access is not acked at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (access && !dmem_ack) state <= S_WAIT;
                S_WAIT:  if (dmem_ack) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // MEM/WB register: bubble on stall or on a flush in IDLE, else capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_w      <= 1'b0;
            reg_write_w  <= 1'b0;
            result_src_w <= '0;
            rd_w         <= '0;
            alu_result_w <= '0;
            read_data_w  <= '0;
            pc_plus4_w   <= '0;
            misalign_w   <= 1'b0;
        end else if (stall_m || (state == S_IDLE && flush_m)) begin
            valid_w     <= 1'b0;
            reg_write_w <= 1'b0;
        end else begin
            valid_w      <= valid_m;
            reg_write_w  <= valid_m & reg_write_m & ~mis_m;
            result_src_w <= result_src_m;
            rd_w         <= rd_m;
            alu_result_w <= alu_result_m;
            read_data_w  <= rdata_fmt;
            pc_plus4_w   <= pc_plus4_m;
            misalign_w   <= mis_m;
        end
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Testbench for mem_stage_hs (D_WIDTH=32): directed steps plus randomized
// accesses checked against an arithmetic reference model of the memory stage.
module tb_mem_stage_hs;

    logic        clk;
    logic        rst_n;
    logic        valid_m, reg_write_m, mem_write_m, mem_read_m;
    logic [1:0]  result_src_m;
    logic [2:0]  funct3_m;
    logic [4:0]  rd_m;
    logic [31:0] alu_result_m, write_data_m, pc_plus4_m;
    logic        flush_m;
    logic        stall_m, reg_write_m_fwd;
    logic [4:0]  rd_m_fwd;
    logic [31:0] alu_result_m_fwd;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        valid_w, reg_write_w;
    logic [1:0]  result_src_w;
    logic [4:0]  rd_w;
    logic [31:0] alu_result_w, read_data_w, pc_plus4_w;
    logic        misalign_w;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage_hs #(.D_WIDTH(32), .A_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_m(valid_m), .reg_write_m(reg_write_m), .mem_write_m(mem_write_m),
        .mem_read_m(mem_read_m), .result_src_m(result_src_m), .funct3_m(funct3_m),
        .rd_m(rd_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
        .pc_plus4_m(pc_plus4_m), .flush_m(flush_m), .stall_m(stall_m),
        .reg_write_m_fwd(reg_write_m_fwd), .rd_m_fwd(rd_m_fwd),
        .alu_result_m_fwd(alu_result_m_fwd), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .valid_w(valid_w),
        .reg_write_w(reg_write_w), .result_src_w(result_src_w), .rd_w(rd_w),
        .alu_result_w(alu_result_w), .read_data_w(read_data_w),
        .pc_plus4_w(pc_plus4_w), .misalign_w(misalign_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic int offset_of(input logic [2:0] f3, input logic [31:0] a);
        int s;
        s = size_of(f3);
        if (s > 4) return 0;
        return ((a % 4) / s) * s;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        int s;
        s = size_of(f3);
        if (s > 4) return 4'h0;
        return 4'(((1 << s) - 1) << offset_of(f3, a));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [63:0] m, r;
        int s;
        s = size_of(f3);
        if (s > 4) return d;
        m = (64'd1 << (8 * s)) - 64'd1;
        r = 64'd0;
        for (int i = 0; i < 4 / s; i++) r = r | ((64'(d) & m) << (8 * s * i));
        return r[31:0];
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [63:0] m, v;
        int s;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 32'h0;
        s = size_of(f3);
        m = (64'd1 << (8 * s)) - 64'd1;
        v = (64'(rd) >> (8 * offset_of(f3, a))) & m;
        if (!f3[2] && v[8*s-1]) v = v | ~m;
        return v[31:0];
    endfunction

    function automatic logic exp_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_CHECK_EN
        return (a % size_of(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic set_idle();
        valid_m = 0; reg_write_m = 0; mem_write_m = 0; mem_read_m = 0;
        result_src_m = 2'd0; funct3_m = 3'd0; rd_m = 5'd0; alu_result_m = 32'd0;
        write_data_m = 32'd0; pc_plus4_m = 32'd0; flush_m = 0; dmem_ack = 0;
        dmem_rdata = 32'd0;
    endtask

    // One memory instruction, entered at posedge+1; acked after 'waits' cycles.
    task automatic mem_op(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] rdat, input int waits,
                          input logic [4:0] rd, input logic rw);
        logic mis;
        int   nw;
        logic [31:0] pc;
        mis = exp_mis(f3, a);
        nw  = mis ? 0 : waits;
        pc  = $urandom;
        valid_m = 1; reg_write_m = rw; mem_write_m = wr; mem_read_m = ~wr;
        result_src_m = 2'(wr ? 0 : 1); funct3_m = f3; rd_m = rd; alu_result_m = a;
        write_data_m = d; pc_plus4_m = pc; flush_m = 0;
        for (int c = 0; c <= nw; c++) begin
            dmem_ack   = (c == nw);
            dmem_rdata = (c == nw) ? rdat : $urandom;
            @(negedge clk);
            chk("req", dmem_req, !mis);
            chk("stall", stall_m, !mis && c < nw);
            chk("fwd_rw", reg_write_m_fwd, rw);
            if (!mis) begin
                chk("addr", dmem_addr, a & 32'hFFFF_FFFC);
                chk("be", dmem_be, exp_be(f3, a));
                chk("we", dmem_we, wr);
                if (wr) chk("wdata", dmem_wdata, exp_wdata(f3, d));
            end
            @(posedge clk); #1;
            if (c < nw) begin
                chk("bubble_valid", valid_w, 0);
                chk("bubble_rw", reg_write_w, 0);
            end else begin
                chk("valid_w", valid_w, 1);
                chk("reg_write_w", reg_write_w, rw && !mis);
                chk("rd_w", rd_w, rd);
                chk("alu_w", alu_result_w, a);
                chk("pc_w", pc_plus4_w, pc);
                chk("misalign_w", misalign_w, mis);
                if (!wr && !mis) chk("read_data_w", read_data_w, exp_load(f3, a, rdat));
            end
        end
        set_idle();
    endtask

    initial begin
        logic [2:0]  f3;
        logic        wr;
        logic [31:0] a;

        // Reset with a pending access on the inputs.
        set_idle();
        rst_n = 0;
        valid_m = 1; mem_read_m = 1; mem_write_m = 1; funct3_m = 3'd2; alu_result_m = 32'h40;
        @(negedge clk);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_stall", stall_m, 0);
        @(posedge clk); #1;
        chk("rst_valid_w", valid_w, 0);
        chk("rst_rw_w", reg_write_w, 0);
        chk("rst_alu_w", alu_result_w, 0);
        chk("rst_read_w", read_data_w, 0);
        chk("rst_pc_w", pc_plus4_w, 0);
        chk("rst_rd_w", rd_w, 0);
        chk("rst_src_w", result_src_w, 0);
        chk("rst_mis_w", misalign_w, 0);
        rst_n = 1;
        set_idle();
        @(posedge clk); #1;

        // Zero-wait LW, 3-wait SB, LB/LBU lane select.
        mem_op(0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 5'd3, 1);
        mem_op(1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 3, 5'd0, 0);
        mem_op(0, 3'd0, 32'h202, 32'h0, 32'h00800000, 0, 5'd4, 1);
        mem_op(0, 3'd4, 32'h202, 32'h0, 32'h00800000, 1, 5'd5, 1);
        // LW at 0x101 (aligned request or misalign trap), illegal load funct3.
        mem_op(0, 3'd2, 32'h101, 32'h0, 32'h12345678, 0, 5'd6, 1);
        mem_op(0, 3'd7, 32'h300, 32'h0, 32'hFFFFFFFF, 0, 5'd7, 1);

        // Non-memory instruction with a stray ack: no request, no stall.
        valid_m = 1; reg_write_m = 1; rd_m = 5'd9; alu_result_m = 32'h1234_5678;
        pc_plus4_m = 32'h0000_0404; dmem_ack = 1;
        @(negedge clk);
        chk("alu_req", dmem_req, 0);
        chk("alu_stall", stall_m, 0);
        chk("alu_fwd_rd", rd_m_fwd, 5'd9);
        chk("alu_fwd_res", alu_result_m_fwd, 32'h1234_5678);
        @(posedge clk); #1;
        chk("alu_valid_w", valid_w, 1);
        chk("alu_rw_w", reg_write_w, 1);
        chk("alu_res_w", alu_result_w, 32'h1234_5678);
        set_idle();

        // Flush of an SW in IDLE.
        valid_m = 1; mem_write_m = 1; funct3_m = 3'd2; alu_result_m = 32'h80; flush_m = 1;
        @(negedge clk);
        chk("flush_req", dmem_req, 0);
        chk("flush_stall", stall_m, 0);
        @(posedge clk); #1;
        chk("flush_valid_w", valid_w, 0);
        set_idle();

        // Flush arriving in WAIT is ignored; the LW completes.
        valid_m = 1; mem_read_m = 1; reg_write_m = 1; funct3_m = 3'd2; rd_m = 5'd11;
        alu_result_m = 32'h0000_0500;
        @(negedge clk);
        chk("fw_stall0", stall_m, 1);
        @(posedge clk); #1;
        flush_m = 1;
        @(negedge clk);
        chk("fw_req1", dmem_req, 1);
        chk("fw_stall1", stall_m, 1);
        @(posedge clk); #1;
        dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("fw_req2", dmem_req, 1);
        @(posedge clk); #1;
        chk("fw_valid_w", valid_w, 1);
        chk("fw_rw_w", reg_write_w, 1);
        chk("fw_read_w", read_data_w, 32'hCAFE_F00D);
        set_idle();

        // Reset during WAIT drops the request immediately and returns to IDLE.
        valid_m = 1; mem_read_m = 1; funct3_m = 3'd2; alu_result_m = 32'h600;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("rw_req_drop", dmem_req, 0);
        chk("rw_stall_drop", stall_m, 0);
        @(posedge clk); #1;
        rst_n = 1;
        set_idle();
        @(negedge clk);
        chk("rw_idle_req", dmem_req, 0);
        chk("rw_valid_w", valid_w, 0);
        @(posedge clk); #1;

        // Randomized loads and stores with random wait counts.
        for (int k = 0; k < 60; k++) begin
            wr = 1'($urandom_range(0, 1));
            if (wr) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end
            a = $urandom;
            mem_op(wr, f3, a, $urandom, $urandom, $urandom_range(0, 3),
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
